// File: rtl/mem_map_pkg.sv
// Address map, STATUS bit layout and decode-target type shared by the
// data-memory stage fabric.
package mem_map_pkg;

  localparam logic [3:0]  RAM_REGION  = 4'h0;
  localparam logic [31:0] MMIO_BASE   = 32'hFFFF_0000;
  localparam logic [31:0] COUNT_OFFS  = 32'h0000_0000;
  localparam logic [31:0] CMP_OFFS    = 32'h0000_0004;
  localparam logic [31:0] STATUS_OFFS = 32'h0000_0008;
  localparam logic [31:0] TXDATA_OFFS = 32'h0000_000C;

  localparam logic [31:0] COUNT_ADDR  = MMIO_BASE + COUNT_OFFS;
  localparam logic [31:0] CMP_ADDR    = MMIO_BASE + CMP_OFFS;
  localparam logic [31:0] STATUS_ADDR = MMIO_BASE + STATUS_OFFS;
  localparam logic [31:0] TXDATA_ADDR = MMIO_BASE + TXDATA_OFFS;

  localparam int unsigned STATUS_FLAG_BIT  = 0;
  localparam int unsigned STATUS_FULL_BIT  = 1;
  localparam int unsigned STATUS_EMPTY_BIT = 2;
  localparam int unsigned STATUS_OVF_BIT   = 3;

  typedef enum logic [2:0] {
    TGT_NONE,
    TGT_RAM,
    TGT_COUNT,
    TGT_CMP,
    TGT_STATUS,
    TGT_TXDATA
  } mmioTarget_t;

  // Decode on the word address; byte offset bits never take part.
  function automatic mmioTarget_t decodeAddr(input logic [29:0] wordAddr);
    if (wordAddr[29:26] == RAM_REGION)  return TGT_RAM;
    if (wordAddr == COUNT_ADDR[31:2])   return TGT_COUNT;
    if (wordAddr == CMP_ADDR[31:2])     return TGT_CMP;
    if (wordAddr == STATUS_ADDR[31:2])  return TGT_STATUS;
    if (wordAddr == TXDATA_ADDR[31:2])  return TGT_TXDATA;
    return TGT_NONE;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-bit pointers; a push is accepted when full
// only if a pop retires an entry in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] head_c,
  output logic             full_c,
  output logic             empty_c,
  output logic             acceptPush_c
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPop;

  assign empty_c      = (wrPtr == rdPtr);
  assign full_c       = (wrPtr[ADDR_W] != rdPtr[ADDR_W]) &&
                        (wrPtr[ADDR_W-1:0] == rdPtr[ADDR_W-1:0]);
  assign doPop        = pop && !empty_c;
  assign acceptPush_c = push && (!full_c || doPop);
  assign head_c       = mem[rdPtr[ADDR_W-1:0]];

  // Storage is cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (acceptPush_c) begin
        mem[wrPtr[ADDR_W-1:0]] <= pushData;
        wrPtr                  <= wrPtr + PTR_W'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data-memory stage fabric: word RAM plus cycle counter, compare timer and
// byte transmit FIFO mapped into the top of the address space.
module dmem_mmio
  import mem_map_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 1024,
  parameter int unsigned TX_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        timer_irq
);

  localparam int unsigned RAM_IDX_W = $clog2(RAM_WORDS);

  logic [31:0]          ram [RAM_WORDS];
  logic [RAM_IDX_W-1:0] ramIdx;
  logic [31:0]          countQ;
  logic [31:0]          cmpQ;
  logic                 flagQ;
  logic                 ovfQ;
  logic [31:0]          statusWord;
  mmioTarget_t          target;
  logic                 ramWr;
  logic                 cmpWr;
  logic                 statusWr;
  logic                 txPush;
  logic                 txPop;
  logic                 txFull;
  logic                 txEmpty;
  logic                 txAccept;
  logic                 timerHit;
  logic                 unusedAddrBits;

  assign unusedAddrBits = ^addr[1:0];

  assign target   = decodeAddr(addr[31:2]);
  assign ramIdx   = addr[RAM_IDX_W+1:2];
  assign ramWr    = mem_write && (target == TGT_RAM);
  assign cmpWr    = mem_write && (target == TGT_CMP);
  assign statusWr = mem_write && (target == TGT_STATUS);
  assign txPush   = mem_write && (target == TGT_TXDATA);
  assign txPop    = tx_valid && tx_ready;
  assign timerHit = (cmpQ != '0) && (countQ == cmpQ);

  always_ff @(posedge clk) begin
    if (ramWr) begin
      ram[ramIdx] <= write_data;
    end
  end

  // Counter, compare register and the two sticky bits; a set beats a clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      countQ <= '0;
      cmpQ   <= '0;
      flagQ  <= 1'b0;
      ovfQ   <= 1'b0;
    end else begin
      countQ <= countQ + 32'd1;
      if (cmpWr) begin
        cmpQ <= write_data;
      end
      if (timerHit) begin
        flagQ <= 1'b1;
      end else if (statusWr && write_data[STATUS_FLAG_BIT]) begin
        flagQ <= 1'b0;
      end
      if (txPush && !txAccept) begin
        ovfQ <= 1'b1;
      end else if (statusWr && write_data[STATUS_OVF_BIT]) begin
        ovfQ <= 1'b0;
      end
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_txFifo (
    .clk          (clk),
    .rst          (rst),
    .push         (txPush),
    .pushData     (write_data[7:0]),
    .pop          (txPop),
    .head_c       (tx_data),
    .full_c       (txFull),
    .empty_c      (txEmpty),
    .acceptPush_c (txAccept)
  );

  assign tx_valid  = !txEmpty;
  assign timer_irq = flagQ;

  always_comb begin
    statusWord                   = '0;
    statusWord[STATUS_FLAG_BIT]  = flagQ;
    statusWord[STATUS_FULL_BIT]  = txFull;
    statusWord[STATUS_EMPTY_BIT] = txEmpty;
    statusWord[STATUS_OVF_BIT]   = ovfQ;
  end

  always_comb begin
    read_data = '0;
    case (target)
      TGT_RAM:    read_data = ram[ramIdx];
      TGT_COUNT:  read_data = countQ;
      TGT_CMP:    read_data = cmpQ;
      TGT_STATUS: read_data = statusWord;
      default:    read_data = '0;
    endcase
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Scoreboard bench for dmem_mmio: stimulus queues expectations from a
// queue/array reference model, an independent monitor compares them.
module tb_dmem_mmio;

  localparam int RAM_WORDS = 1024;
  localparam int TX_DEPTH  = 8;
  localparam logic [31:0] A_COUNT  = 32'hFFFF_0000;
  localparam logic [31:0] A_CMP    = 32'hFFFF_0004;
  localparam logic [31:0] A_STATUS = 32'hFFFF_0008;
  localparam logic [31:0] A_TX     = 32'hFFFF_000C;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        timer_irq;

  always #5 clk = ~clk;

  dmem_mmio #(
    .RAM_WORDS (RAM_WORDS),
    .TX_DEPTH  (TX_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_write  (mem_write),
    .addr       (addr),
    .write_data (write_data),
    .read_data  (read_data),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .timer_irq  (timer_irq)
  );

  // Reference model state
  logic [31:0] cntM;
  logic [31:0] cmpM;
  bit          flagM;
  bit          ovfM;
  byte unsigned fifoM[$];
  logic [31:0] ramM[int];

  typedef struct {
    int          kind;   // 0 read_data, 1 tx_valid, 2 timer_irq, 3 tx_data
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t         expQ[$];
  byte unsigned txQ[$];
  int vectors = 0;
  int miscompares = 0;

  function automatic void modelReset();
    cntM  = '0;
    cmpM  = '0;
    flagM = 1'b0;
    ovfM  = 1'b0;
    fifoM.delete();
    txQ.delete();
  endfunction

  function automatic bit modelRead(input logic [31:0] a, output logic [31:0] v);
    logic [31:0] w;
    int idx;
    v = '0;
    if (a < 32'h1000_0000) begin
      idx = int'((a >> 2) % RAM_WORDS);
      if (!ramM.exists(idx)) return 1'b0;
      v = ramM[idx];
      return 1'b1;
    end
    w = a & 32'hFFFF_FFFC;
    if (w == A_COUNT)       v = cntM;
    else if (w == A_CMP)    v = cmpM;
    else if (w == A_STATUS) v = {28'd0, ovfM, fifoM.size() == 0, fifoM.size() == TX_DEPTH, flagM};
    return 1'b1;
  endfunction

  function automatic void modelEdge(input bit mw, input logic [31:0] a,
                                    input logic [31:0] wd, input bit rdy);
    int occ = fifoM.size();
    bit popNow = (occ > 0) && rdy;
    bit hit = (cmpM != 0) && (cntM == cmpM);
    logic [31:0] w = a & 32'hFFFF_FFFC;
    if (popNow) void'(fifoM.pop_front());
    if (mw && a < 32'h1000_0000) begin
      ramM[int'((a >> 2) % RAM_WORDS)] = wd;
    end else if (mw) begin
      if (w == A_TX) begin
        if (occ < TX_DEPTH || popNow) begin
          fifoM.push_back(wd[7:0]);
          txQ.push_back(wd[7:0]);
        end else begin
          ovfM = 1'b1;
        end
      end
      if (w == A_CMP) cmpM = wd;
      if (w == A_STATUS) begin
        if (wd[0]) flagM = 1'b0;
        if (wd[3]) ovfM = 1'b0;
      end
    end
    if (hit) flagM = 1'b1;
    cntM = cntM + 32'd1;
  endfunction

  function automatic void pushExp(input int kind, input logic [31:0] e, input string tag);
    exp_t x;
    x.kind = kind;
    x.exp  = e;
    x.tag  = tag;
    expQ.push_back(x);
  endfunction

  // One clock cycle: drive, queue expectations for this cycle, advance model at the edge.
  task automatic step(input bit r, input bit mw, input logic [31:0] a,
                      input logic [31:0] wd, input bit rdy, input string tag);
    logic [31:0] rv;
    rst        = r;
    mem_write  = mw;
    addr       = a;
    write_data = wd;
    tx_ready   = rdy;
    if (!r) modelReset();
    if (modelRead(a, rv)) pushExp(0, rv, tag);
    pushExp(1, 32'(fifoM.size() > 0), {tag, "/tx_valid"});
    pushExp(2, 32'(flagM), {tag, "/timer_irq"});
    if (fifoM.size() > 0) pushExp(3, 32'(fifoM[0]), {tag, "/tx_data"});
    else if (!r) pushExp(3, 32'd0, {tag, "/tx_data_rst"});
    @(posedge clk);
    if (r) modelEdge(mw, a, wd, rdy);
    #1;
  endtask

  task automatic idle(input bit rdy, input string tag);
    step(1'b1, 1'b0, A_STATUS, 32'd0, rdy, tag);
  endtask

  // Monitor: per-cycle expectations plus the transmitted byte stream.
  initial begin : monitor
    exp_t e;
    logic [31:0] act;
    byte unsigned b;
    forever begin
      @(negedge clk);
      while (expQ.size() > 0) begin
        e = expQ.pop_front();
        case (e.kind)
          0:       act = read_data;
          1:       act = {31'd0, tx_valid};
          2:       act = {31'd0, timer_irq};
          default: act = {24'd0, tx_data};
        endcase
        vectors++;
        if (act !== e.exp) begin
          miscompares++;
          $display("FAIL %s: got %h expected %h", e.tag, act, e.exp);
        end
      end
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
        vectors++;
        if (txQ.size() == 0) begin
          miscompares++;
          $display("FAIL tx_stream: got byte %h expected no transfer", tx_data);
        end else begin
          b = txQ.pop_front();
          if (tx_data !== b) begin
            miscompares++;
            $display("FAIL tx_stream: got %h expected %h", tx_data, b);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [31:0] a;
    logic [31:0] wd;
    int sel;
    int guard;
    bit r;
    bit mw;
    bit rdy;

    modelReset();
    repeat (3) step(1'b0, 1'b0, A_STATUS, 32'd0, 1'b0, "reset_state");

    // Counter from release, then writes ignored
    repeat (5) step(1'b1, 1'b0, A_COUNT, 32'd0, 1'b0, "count_run");
    step(1'b1, 1'b0, A_COUNT, 32'd0, 1'b0, "count_after5");
    step(1'b1, 1'b1, A_COUNT, 32'hAAAA_5555, 1'b0, "count_write");
    step(1'b1, 1'b0, A_COUNT, 32'd0, 1'b0, "count_ro");

    // RAM store/load, byte offset, unmapped, alias, same-cycle read-old
    step(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, "ram_store");
    step(1'b1, 1'b0, 32'h0000_0010, 32'd0, 1'b0, "ram_load");
    step(1'b1, 1'b0, 32'h0000_0013, 32'd0, 1'b0, "ram_load_offset");
    step(1'b1, 1'b0, 32'h1234_5678, 32'd0, 1'b0, "unmapped_read");
    step(1'b1, 1'b1, 32'h1234_5678, 32'h5555_5555, 1'b0, "unmapped_write");
    step(1'b1, 1'b0, 32'h0000_1010, 32'd0, 1'b0, "ram_alias");
    step(1'b1, 1'b1, 32'h0000_0010, 32'h1111_2222, 1'b0, "ram_rw_same");
    step(1'b1, 1'b0, 32'h0000_0010, 32'd0, 1'b0, "ram_load_new");
    step(1'b1, 1'b0, A_TX, 32'd0, 1'b0, "txdata_read");

    // Timer: match sets flag, W1C clears, coincident set wins
    step(1'b1, 1'b1, A_CMP, cntM + 32'd10, 1'b0, "cmp_write");
    step(1'b1, 1'b0, A_CMP, 32'd0, 1'b0, "cmp_read");
    repeat (14) idle(1'b0, "timer_wait");
    step(1'b1, 1'b1, A_STATUS, 32'd1, 1'b0, "flag_clear");
    idle(1'b0, "flag_cleared");
    step(1'b1, 1'b1, A_CMP, cntM + 32'd4, 1'b0, "cmp_write2");
    guard = 0;
    while (cntM != cmpM && guard < 20) begin
      idle(1'b0, "timer_wait2");
      guard++;
    end
    step(1'b1, 1'b1, A_STATUS, 32'd1, 1'b0, "clear_vs_set");
    idle(1'b0, "set_wins");
    step(1'b1, 1'b1, A_CMP, 32'd0, 1'b0, "cmp_disable");
    step(1'b1, 1'b1, A_STATUS, 32'd1, 1'b0, "flag_clear2");
    repeat (3) idle(1'b0, "timer_off");

    // TX ordering and draining
    step(1'b1, 1'b1, A_TX, 32'h41, 1'b0, "tx_push");
    step(1'b1, 1'b1, A_TX, 32'h42, 1'b0, "tx_push");
    step(1'b1, 1'b1, A_TX, 32'h43, 1'b0, "tx_push");
    idle(1'b0, "tx_held");
    repeat (4) idle(1'b1, "tx_drain");

    // Overflow when full, then full push with concurrent pop
    for (int i = 0; i < TX_DEPTH; i++) step(1'b1, 1'b1, A_TX, 32'(8'h60 + i), 1'b0, "tx_fill");
    step(1'b1, 1'b1, A_TX, 32'h99, 1'b0, "tx_overflow_push");
    idle(1'b0, "tx_overflow_status");
    step(1'b1, 1'b1, A_STATUS, 32'h8, 1'b0, "ovf_clear");
    step(1'b1, 1'b1, A_TX, 32'h77, 1'b1, "tx_full_push_pop");
    idle(1'b0, "tx_no_overflow");
    repeat (10) idle(1'b1, "tx_drain2");

    // Reset in the middle of a drain
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, A_TX, 32'(8'hC0 + i), 1'b0, "tx_queue4");
    step(1'b1, 1'b1, A_CMP, 32'd500, 1'b1, "pre_reset");
    step(1'b0, 1'b0, A_STATUS, 32'd0, 1'b1, "reset_async");
    step(1'b0, 1'b0, A_STATUS, 32'd0, 1'b1, "reset_hold");
    step(1'b1, 1'b0, A_COUNT, 32'd0, 1'b0, "post_reset_count");
    step(1'b1, 1'b0, A_CMP, 32'd0, 1'b0, "post_reset_cmp");
    step(1'b1, 1'b0, A_STATUS, 32'd0, 1'b0, "post_reset_status");

    // Randomized traffic over every region
    for (int n = 0; n < 600; n++) begin
      r   = ($urandom_range(0, 249) != 0);
      mw  = ($urandom_range(0, 1) == 1);
      rdy = ($urandom_range(0, 9) < 4);
      wd  = $urandom;
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1, 2, 3: a = (32'($urandom_range(0, 63)) << 2) | (32'($urandom_range(0, 3)) << 12);
        4: a = A_COUNT;
        5: begin
          a  = A_CMP;
          wd = ($urandom_range(0, 7) == 0) ? 32'd0 : cntM + 32'($urandom_range(1, 12));
        end
        6: a = A_STATUS;
        7, 8: a = A_TX;
        default: a = ($urandom_range(0, 1) == 1) ? 32'hFFFF_0010 : (32'h4000_0000 | 32'($urandom));
      endcase
      a = a | 32'($urandom_range(0, 3));
      step(r, mw, a, wd, rdy, "random");
    end
    repeat (12) idle(1'b1, "final_drain");

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
- Data-memory stage fabric sitting directly downstream of the pipelined core's memory stage.
- Consumes alu_outM / write_data / mem_writeM and returns read_data in the same cycle.
- Contains a word-addressed data RAM plus a small memory-mapped peripheral window:
  - free-running cycle counter
  - compare timer with sticky flag and interrupt
  - byte-wide transmit FIFO drained over a valid/ready handshake.

Parameters:
- RAM_WORDS, 1024, data RAM depth in 32-bit words (power of 2).
- TX_DEPTH, 8, transmit FIFO depth in entries (power of 2, >=2).

Ports:
- clk  input  1  Single clock; all state updates on the rising edge.
- rst  input  1  Asynchronous, active-low reset.
- mem_write  input  1  Store strobe from the memory stage (mem_writeM).
- addr  input  32  Byte address from the memory stage (alu_outM).
- write_data  input  32  Store data.
- read_data  output  32  Load data, combinational from addr.
- tx_data  output  8  Head byte of the TX FIFO.
- tx_valid  output  1  TX FIFO non-empty.
- tx_ready  input  1  Consumer accepts tx_data when tx_valid is also high.
- timer_irq  output  1  Level copy of the timer flag.

Behaviour:
- Address decode (addr[1:0] ignored, no alignment fault):
  - addr[31:28]==0 -> RAM, word index addr[log2(RAM_WORDS)+1:2]; upper RAM-region bits alias.
  - 0xFFFF0000 COUNT (RO)
  - 0xFFFF0004 CMP (RW)
  - 0xFFFF0008 STATUS
  - 0xFFFF000C TXDATA (WO)
  - Any other address: reads return 0, writes have no effect.
- RAM:
  - Write at the rising edge when mem_write and RAM region.
  - Read is combinational.
  - A read and write to the same word in the same cycle returns the old data.
  - RAM is not reset.
- COUNT:
  - Increments every cycle after reset; wraps from 0xFFFFFFFF to 0.
  - Reads return the current registered value.
  - Writes are ignored.
- CMP:
  - Written with write_data at the edge.
  - When COUNT==CMP and CMP!=0, the timer flag sets on the next edge.
  - CMP==0 disables the timer.
- STATUS read value:
  - bit0 timer flag
  - bit1 tx_full
  - bit2 tx_empty
  - bit3 tx_overflow (sticky)
  - all other bits 0
- STATUS write: write-1-to-clear on bit0 and bit3; other bits ignored.
  - If a set and a clear of the same bit occur in the same cycle, set wins.
- TXDATA:
  - A write pushes write_data[7:0].
  - Push while full is dropped and sets tx_overflow, unless a pop occurs the same cycle; in that case the push is accepted and overflow does not set.
  - Reads of TXDATA return 0.
- TX FIFO:
  - Pop when tx_valid && tx_ready.
  - tx_data is the registered head entry.
  - No bypass: a push into an empty FIFO raises tx_valid on the following cycle.
  - Simultaneous push and pop when non-empty keeps the occupancy unchanged.
  - Pointers wrap modulo TX_DEPTH; full and empty are distinguished by an extra pointer bit.
- timer_irq equals the timer flag; it is registered, with no combinational path from inputs.
- Reset values (asynchronous assertion; deassertion is sampled at the next edge):
  - COUNT=0, CMP=0, flag=0, overflow=0
  - FIFO empty
  - tx_valid=0, tx_data=0, timer_irq=0
- read_data has no reset value; it always reflects the current decode.
- Reset asserted mid-transfer discards all FIFO contents. The consumer sees tx_valid drop asynchronously.

Decomposition:
- Shared package mem_map_pkg:
  - region base and register offset constants
  - STATUS bit indices
  - an enumerated decode-target type (RAM, COUNT, CMP, STATUS, TXDATA, NONE).
- One sub-module: sync_fifo, parameterised on width and depth, used for the TX FIFO. The RAM, timer and decode logic stay in dmem_mmio.

Test Plan:
- Store 0xDEADBEEF to 0x00000010, load 0x00000010 next cycle -> read_data=0xDEADBEEF; load 0x00000013 -> same word; load 0x12345678 -> 0.
- Release reset, read COUNT after 5 edges -> 5; write 0xAAAA5555 to COUNT -> COUNT is unaffected and continues incrementing.
- Write CMP=20 at COUNT=10 -> timer_irq rises the edge after COUNT==20, STATUS bit0=1. Write STATUS=0x1 -> flag clears. A clear coincident with a set leaves the flag at 1.
- Push 0x41,0x42,0x43 with tx_ready=0 -> tx_valid=1, tx_data=0x41, STATUS bit2=0. Raise tx_ready -> bytes 0x41,0x42,0x43 on successive cycles, then tx_valid=0 and bit2=1.
- Fill TX_DEPTH=8 entries, push a 9th with tx_ready=0 -> dropped, STATUS bit3=1. Repeat when full with tx_ready=1 -> accepted, no overflow.
- Assert rst mid-drain with 4 queued bytes -> tx_valid=0 immediately; after release FIFO is empty, COUNT=0, CMP=0, timer_irq=0.
